// File: rtl/battleship_turn_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : battleship_turn_ctrl
//  Purpose  : Battleship turn sequencer. Moves the player cursor, fires player
//             and PC shots through one request/acknowledge port to the shared
//             board-lookup unit, tracks boats left on each side, enforces the
//             player turn timeout and declares the winner.
//  Revision : 1.0  initial release
// ============================================================================
module battleship_turn_ctrl #(
  parameter int BOARD_N        = 5,
  parameter int BOATS          = 5,
  parameter int TIMEOUT_CYCLES = 750_000_000
) (
  input  logic       clk,
  input  logic       rstSwitch,
  input  logic       startGame,
  input  logic       rowPulse,
  input  logic       colPulse,
  input  logic       selectPulse,
  output logic [2:0] cursorRow,
  output logic [2:0] cursorCol,
  output logic       shotReq,
  output logic [2:0] shotRow,
  output logic [2:0] shotCol,
  output logic       shotTarget,
  input  logic       shotAck,
  input  logic       shotHit,
  input  logic       shotSunk,
  input  logic       shotRepeat,
  output logic       pcNext,
  input  logic       pcValid,
  input  logic [2:0] pcRow,
  input  logic [2:0] pcCol,
  output logic [2:0] pcBoatsLeft,
  output logic [2:0] playerBoatsLeft,
  output logic [2:0] gameState,
  output logic       playerWon,
  output logic       pcWon
);

  // Game phases; the encoding is visible on gameState.
  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_P_AIM   = 3'd1;
  localparam logic [2:0] c_P_FIRE  = 3'd2;
  localparam logic [2:0] c_PC_REQ  = 3'd3;
  localparam logic [2:0] c_PC_FIRE = 3'd4;
  localparam logic [2:0] c_P_WIN   = 3'd5;
  localparam logic [2:0] c_PC_WIN  = 3'd6;

  localparam int         TW          = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] c_TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] c_LAST_CELL = 3'(BOARD_N - 1);
  localparam logic [2:0] c_BOATS     = 3'(BOATS);

  logic [2:0]    r_state;
  logic [2:0]    r_curRow;
  logic [2:0]    r_curCol;
  logic          r_shotReq;
  logic [2:0]    r_shotRow;
  logic [2:0]    r_shotCol;
  logic          r_shotTarget;
  logic          r_fromTimeout;
  logic          r_pcNext;
  logic [2:0]    r_pcBoats;
  logic [2:0]    r_plBoats;
  logic          r_playerWon;
  logic          r_pcWon;
  logic [TW-1:0] r_timer;

  logic [2:0]    w_rowNext;
  logic [2:0]    w_colNext;
  logic          w_timeout;
  logic          w_ackSeen;
  logic          w_unused;

  // Cursor wrap, timer expiry and qualified acknowledge.
  assign w_rowNext = (r_curRow == c_LAST_CELL) ? 3'd0 : r_curRow + 3'd1;
  assign w_colNext = (r_curCol == c_LAST_CELL) ? 3'd0 : r_curCol + 3'd1;
  assign w_timeout = (r_timer >= c_TO_LAST);
  assign w_ackSeen = r_shotReq & shotAck;

  // Hit versus miss does not change the turn sequence; only sunk/repeat do.
  assign w_unused  = shotHit;

  // Turn sequencer: state, cursor, shot latch, handshake, boat counts, timer.
  always_ff @(posedge clk or negedge rstSwitch) begin
    if (!rstSwitch) begin
      r_state       <= c_IDLE;
      r_curRow      <= 3'd0;
      r_curCol      <= 3'd0;
      r_shotReq     <= 1'b0;
      r_shotRow     <= 3'd0;
      r_shotCol     <= 3'd0;
      r_shotTarget  <= 1'b0;
      r_fromTimeout <= 1'b0;
      r_pcNext      <= 1'b0;
      r_pcBoats     <= c_BOATS;
      r_plBoats     <= c_BOATS;
      r_playerWon   <= 1'b0;
      r_pcWon       <= 1'b0;
      r_timer       <= '0;
    end else begin
      r_pcNext <= 1'b0;
      case (r_state)
        c_IDLE, c_P_WIN, c_PC_WIN: begin
          if (startGame) begin
            r_pcBoats   <= c_BOATS;
            r_plBoats   <= c_BOATS;
            r_curRow    <= 3'd0;
            r_curCol    <= 3'd0;
            r_timer     <= '0;
            r_playerWon <= 1'b0;
            r_pcWon     <= 1'b0;
            r_state     <= c_P_AIM;
          end
        end
        c_P_AIM: begin
          // Saturate at the expiry value so a resumed turn fires at once.
          if (!w_timeout) begin
            r_timer <= r_timer + TW'(1);
          end
          if (selectPulse || w_timeout) begin
            // Firing freezes the cursor; the shot uses the pre-pulse position.
            r_shotRow     <= r_curRow;
            r_shotCol     <= r_curCol;
            r_shotTarget  <= 1'b0;
            r_fromTimeout <= ~selectPulse;
            r_shotReq     <= 1'b1;
            r_state       <= c_P_FIRE;
          end else begin
            if (rowPulse) r_curRow <= w_rowNext;
            if (colPulse) r_curCol <= w_colNext;
          end
        end
        c_P_FIRE: begin
          if (w_ackSeen) begin
            r_shotReq <= 1'b0;
            if (shotRepeat) begin
              // A repeated player choice is retried; a repeated timeout
              // shot forfeits the turn.
              if (r_fromTimeout) begin
                r_pcNext <= 1'b1;
                r_state  <= c_PC_REQ;
              end else begin
                r_state  <= c_P_AIM;
              end
            end else if (shotSunk && (r_pcBoats == 3'd1)) begin
              r_pcBoats   <= 3'd0;
              r_playerWon <= 1'b1;
              r_state     <= c_P_WIN;
            end else begin
              if (shotSunk && (r_pcBoats != 3'd0)) begin
                r_pcBoats <= r_pcBoats - 3'd1;
              end
              r_pcNext <= 1'b1;
              r_state  <= c_PC_REQ;
            end
          end
        end
        c_PC_REQ: begin
          if (pcValid) begin
            r_shotRow    <= pcRow;
            r_shotCol    <= pcCol;
            r_shotTarget <= 1'b1;
            r_shotReq    <= 1'b1;
            r_state      <= c_PC_FIRE;
          end
        end
        c_PC_FIRE: begin
          if (w_ackSeen) begin
            r_shotReq <= 1'b0;
            if (shotRepeat) begin
              r_pcNext <= 1'b1;
              r_state  <= c_PC_REQ;
            end else if (shotSunk && (r_plBoats == 3'd1)) begin
              r_plBoats <= 3'd0;
              r_pcWon   <= 1'b1;
              r_state   <= c_PC_WIN;
            end else begin
              if (shotSunk && (r_plBoats != 3'd0)) begin
                r_plBoats <= r_plBoats - 3'd1;
              end
              r_timer <= '0;
              r_state <= c_P_AIM;
            end
          end
        end
        default: begin
          r_shotReq <= 1'b0;
          r_state   <= c_IDLE;
        end
      endcase
    end
  end

  assign cursorRow       = r_curRow;
  assign cursorCol       = r_curCol;
  assign shotReq         = r_shotReq;
  assign shotRow         = r_shotRow;
  assign shotCol         = r_shotCol;
  assign shotTarget      = r_shotTarget;
  assign pcNext          = r_pcNext;
  assign pcBoatsLeft     = r_pcBoats;
  assign playerBoatsLeft = r_plBoats;
  assign gameState       = r_state;
  assign playerWon       = r_playerWon;
  assign pcWon           = r_pcWon;

endmodule
`default_nettype wire
